// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the sequential matrix ALU.
//   - op-code encodings
//   - FSM state encoding
//   - saturate(): clamps a sign-extended value to an ew-bit signed range
//   - req_invalid(): flags a reserved op or an out-of-range matrix size
package matrix_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_SCAL = 3'b011;
  localparam logic [2:0] OP_RSVD = 3'b100;
  localparam logic [2:0] OP_TRN  = 3'b101;
  localparam logic [2:0] OP_OPP  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MAC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Working width of saturate(). Callers sign-extend their (narrower) input
  // to this width and truncate the return value to ew bits.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] saturate(
    input  logic signed [SAT_W-1:0] v,
    input  int                      ew,
    output logic                    clamped
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] r;
    hi      = (64'sd1 <<< (ew - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (ew - 1));
    r       = v;
    clamped = 1'b0;
    if (v > hi) begin
      r       = hi;
      clamped = 1'b1;
    end else if (v < lo) begin
      r       = lo;
      clamped = 1'b1;
    end
    return r;
  endfunction

  function automatic logic req_invalid(
    input logic [2:0] op,
    input logic [2:0] size,
    input int         n
  );
    return (op == OP_RSVD) || (size < 3'd2) || (int'(size) > n);
  endfunction

endpackage

// File: rtl/matrix_alu_seq_mac.sv
// mat_mac: one signed EW x EW multiplier feeding an AW-bit accumulator.
// sum_o/ovf_o give the saturated value of (acc + a*b) every cycle, so the
// caller can write an element on the same edge the last product lands.
//   clk, rst_n   : clock, async active-low reset
//   acc_en_i     : acc <= acc + a*b
//   acc_clr_i    : acc <= 0 (wins over acc_en_i)
//   a_i, b_i     : signed operands
//   sum_o, ovf_o : saturated acc + a*b and its clamp flag
module mat_mac
  import matrix_alu_pkg::*;
#(
  parameter int EW = 8,
  parameter int AW = 2 * EW + 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc_en_i,
  input  logic                 acc_clr_i,
  input  logic signed [EW-1:0] a_i,
  input  logic signed [EW-1:0] b_i,
  output logic signed [EW-1:0] sum_o,
  output logic                 ovf_o
);

  logic signed [2*EW-1:0] prod;
  logic signed [AW-1:0]   total;
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   acc_d;
  logic                   clamped;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    clamped = 1'b0;
    prod    = (2*EW)'(a_i) * (2*EW)'(b_i);
    total   = acc_q + AW'(prod);
    sum_o   = EW'(saturate(SAT_W'(total), EW, clamped));
    ovf_o   = clamped;
    acc_d   = acc_q;
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = total;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_alu_seq.sv
// matrix_alu_seq: sequential N x N signed matrix ALU with start/done handshake.
//   clk, rst_n : clock, async active-low reset
//   start      : request, sampled only in IDLE
//   op, size   : operation code and active dimension (2..N)
//   a, b       : row-major operand matrices, element (i,j) at (i*N+j)*EW
//   busy       : high outside IDLE
//   done, err  : one-cycle completion pulse and its error qualifier
//   result     : registered result matrix, same layout as a
//   ovf        : per-element saturation flag, index i*N+j
// Elementwise ops finish in one EXEC cycle using N*N parallel lanes; matrix
// multiply walks (i,j,k) through a single shared MAC, one product per cycle.
module matrix_alu_seq
  import matrix_alu_pkg::*;
#(
  parameter int EW = 8,
  parameter int N  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [2:0]          size,
  input  logic [N*N*EW-1:0]   a,
  input  logic [N*N*EW-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [N*N*EW-1:0]   result,
  output logic [N*N-1:0]      ovf
);

  localparam int MW  = N * N * EW;
  localparam int EIW = $clog2(N * N);
  localparam int BIW = $clog2(MW);

  state_e              state_q, state_d;
  logic [MW-1:0]       a_q, b_q, result_q;
  logic [N*N-1:0]      ovf_q;
  logic [2:0]          op_q, size_q;
  logic [2:0]          i_q, j_q, k_q;
  logic                err_q;
  logic                bad_q;
  logic                last_i, last_j, last_k;

  wire  [MW-1:0]       lane_res;
  wire  [N*N-1:0]      lane_ovf;

  logic [EIW-1:0]      e_ij;
  logic [BIW-1:0]      l_ik, l_kj, l_ij;
  logic signed [EW-1:0] mac_a, mac_b, mac_sum, b0;
  logic                mac_ovf, mac_en, mac_clr;

  assign bad_q  = req_invalid(op_q, size_q, N);
  assign last_k = (k_q == size_q - 3'd1);
  assign last_j = (j_q == size_q - 3'd1);
  assign last_i = (i_q == size_q - 3'd1);
  assign b0     = b_q[EW-1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: if (start) begin
        // Only a well-formed multiply goes to MAC; errors take the EXEC path.
        state_d = (op == OP_MUL && !req_invalid(op, size, N)) ? ST_MAC : ST_EXEC;
      end
      ST_EXEC: state_d = ST_DONE;
      ST_MAC:  if (last_i && last_j && last_k) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- MAC path
  always_comb begin
    e_ij  = EIW'(int'(i_q) * N + int'(j_q));
    l_ij  = BIW'((int'(i_q) * N + int'(j_q)) * EW);
    l_ik  = BIW'((int'(i_q) * N + int'(k_q)) * EW);
    l_kj  = BIW'((int'(k_q) * N + int'(j_q)) * EW);
    mac_a = a_q[l_ik +: EW];
    mac_b = b_q[l_kj +: EW];
    mac_en  = (state_q == ST_MAC);
    mac_clr = (state_q == ST_MAC) && last_k;
  end

  mat_mac #(.EW(EW)) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_en_i  (mac_en),
    .acc_clr_i (mac_clr),
    .a_i       (mac_a),
    .b_i       (mac_b),
    .sum_o     (mac_sum),
    .ovf_o     (mac_ovf)
  );

  // ---------------------------------------------------------------- lanes
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam int E = gi * N + gj;
      localparam int T = gj * N + gi;

      logic signed [EW-1:0]    ai, bi, at, sc_sum, val;
      logic signed [SAT_W-1:0] wide;
      logic                    sc_ovf, flg, use_sat, sat_ovf;

      assign ai = a_q[E*EW +: EW];
      assign bi = b_q[E*EW +: EW];
      assign at = a_q[T*EW +: EW];

      // Scalar multiply reuses the MAC block with the accumulator held at 0.
      mat_mac #(.EW(EW)) u_scal (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc_en_i  (1'b0),
        .acc_clr_i (1'b0),
        .a_i       (ai),
        .b_i       (b0),
        .sum_o     (sc_sum),
        .ovf_o     (sc_ovf)
      );

      always_comb begin
        wide    = '0;
        use_sat = 1'b0;
        sat_ovf = 1'b0;
        val     = '0;
        flg     = 1'b0;
        case (op_q)
          OP_ADD:  begin wide = SAT_W'(ai) + SAT_W'(bi); use_sat = 1'b1; end
          OP_SUB:  begin wide = SAT_W'(ai) - SAT_W'(bi); use_sat = 1'b1; end
          OP_OPP:  begin wide = -SAT_W'(ai);             use_sat = 1'b1; end
          OP_SCAL: begin val = sc_sum; flg = sc_ovf; end
          OP_TRN:  val = at;
          default: ;
        endcase
        if (use_sat) begin
          val = EW'(saturate(wide, EW, sat_ovf));
          flg = sat_ovf;
        end
        if (!(3'(gi) < size_q && 3'(gj) < size_q)) begin
          val = '0;
          flg = 1'b0;
        end
      end

      assign lane_res[E*EW +: EW] = val;
      assign lane_ovf[E]          = flg;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand latches are wide but still plain flops, so they are
      // reset along with everything else; nothing here is a RAM.
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      size_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          a_q    <= a;
          b_q    <= b;
          op_q   <= op;
          size_q <= size;
          i_q    <= '0;
          j_q    <= '0;
          k_q    <= '0;
          // A valid op starts from a clean matrix; a rejected one leaves the
          // previous result in place.
          if (!req_invalid(op, size, N)) begin
            result_q <= '0;
            ovf_q    <= '0;
          end
        end
        ST_EXEC: begin
          if (bad_q) begin
            err_q <= 1'b1;
          end else begin
            result_q <= lane_res;
            ovf_q    <= lane_ovf;
          end
        end
        ST_MAC: begin
          if (last_k) begin
            result_q[l_ij +: EW] <= mac_sum;
            ovf_q[e_ij]          <= mac_ovf;
            k_q <= '0;
            if (last_j) begin
              j_q <= '0;
              i_q <= i_q + 3'd1;
            end else begin
              j_q <= j_q + 3'd1;
            end
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        ST_DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Self-checking bench for matrix_alu_seq: a reference model computes each
// expected matrix when the request is driven, the entry is queued, and it is
// popped and compared when done is observed.
module tb_matrix_alu_seq;
  import matrix_alu_pkg::*;

  localparam int EW = 8;
  localparam int N  = 5;
  localparam int MW = N * N * EW;

  typedef logic [MW-1:0]  mat_t;
  typedef logic [N*N-1:0] ovf_t;
  typedef struct {
    mat_t res;
    ovf_t ovf;
    logic err;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op    = '0;
  logic [2:0] size  = '0;
  mat_t       a     = '0;
  mat_t       b     = '0;
  logic       busy, done, err;
  mat_t       result;
  ovf_t       ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  mat_t model_res = '0;
  ovf_t model_ovf = '0;

  always #5 clk = ~clk;

  matrix_alu_seq #(.EW(EW), .N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .size   (size),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result),
    .ovf    (ovf)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  function automatic int el(input mat_t m, input int i, input int j);
    logic signed [EW-1:0] t;
    t = m[(i*N+j)*EW +: EW];
    return int'(t);
  endfunction

  function automatic mat_t set_el(input mat_t m, input int i, input int j, input int v);
    mat_t r;
    r = m;
    r[(i*N+j)*EW +: EW] = EW'(v);
    return r;
  endfunction

  function automatic mat_t fill(input int v);
    mat_t r;
    r = '0;
    for (int e = 0; e < N*N; e++) r[e*EW +: EW] = EW'(v);
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t r;
    r = '0;
    for (int e = 0; e < N*N; e++) r[e*EW +: EW] = EW'($urandom);
    return r;
  endfunction

  function automatic exp_t model(input logic [2:0] o, input int s, input mat_t ma, input mat_t mb);
    exp_t e;
    int   v, hi, lo;
    bit   c;
    hi    = (1 << (EW - 1)) - 1;
    lo    = -(1 << (EW - 1));
    e.err = (o == OP_RSVD) || (s < 2) || (s > N);
    e.res = model_res;
    e.ovf = model_ovf;
    if (e.err) return e;
    e.res = '0;
    e.ovf = '0;
    for (int i = 0; i < s; i++) begin
      for (int j = 0; j < s; j++) begin
        v = 0;
        case (o)
          OP_ADD:  v = el(ma, i, j) + el(mb, i, j);
          OP_SUB:  v = el(ma, i, j) - el(mb, i, j);
          OP_MUL:  for (int k = 0; k < s; k++) v += el(ma, i, k) * el(mb, k, j);
          OP_SCAL: v = el(ma, i, j) * el(mb, 0, 0);
          OP_TRN:  v = el(ma, j, i);
          OP_OPP:  v = -el(ma, i, j);
          default: v = 0;
        endcase
        c = 1'b0;
        if (v > hi) begin v = hi; c = 1'b1; end
        if (v < lo) begin v = lo; c = 1'b1; end
        e.res[(i*N+j)*EW +: EW] = EW'(v);
        e.ovf[i*N+j]            = c;
      end
    end
    return e;
  endfunction

  // Waits for done after edge 0 and checks latency, busy and the queued entry.
  task automatic wait_done(input string name, input int lat, input int inject_at);
    int   cycles;
    bit   busy_gap;
    exp_t e;
    cycles   = 0;
    busy_gap = 1'b0;
    do begin
      @(posedge clk);
      #1 start = 1'b0;
      cycles++;
      @(negedge clk);
      if (busy !== 1'b1) busy_gap = 1'b1;
      if (done !== 1'b1 && cycles == inject_at) begin
        op    = OP_CLR;
        size  = 3'd2;
        start = 1'b1;
      end
    end while (done !== 1'b1 && cycles < 300);

    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done not seen after %0d cycles", name, cycles);
    end
    checks++;
    if (cycles != lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cycles, lat);
    end
    checks++;
    if (busy_gap) begin
      errors++;
      $display("FAIL %s_busy: busy dropped before or at done, expected high throughout", name);
    end

    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: no expected entry queued", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (result !== e.res) begin
        errors++;
        $display("FAIL %s_result: got %h expected %h", name, result, e.res);
      end
      checks++;
      if (ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s_ovf: got %h expected %h", name, ovf, e.ovf);
      end
      checks++;
      if (err !== e.err) begin
        errors++;
        $display("FAIL %s_err: got %b expected %b", name, err, e.err);
      end
    end

    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: done=%b busy=%b err=%b expected 0 0 0", name, done, busy, err);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input int s, input mat_t ma, input mat_t mb,
                        input int lat, input string name, input int inject_at);
    exp_t e;
    e = model(o, s, ma, mb);
    model_res = e.res;
    model_ovf = e.ovf;
    exp_q.push_back(e);
    @(negedge clk);
    op    = o;
    size  = 3'(s);
    a     = ma;
    b     = mb;
    start = 1'b1;
    @(posedge clk);
    // Scramble inputs right after the sampling edge; the latched copy must win.
    #1 start = 1'b0;
    op   = ~o;
    size = 3'(s + 1);
    a    = ~ma;
    b    = ~mb;
    wait_done(name, lat, inject_at);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (result !== '0)  begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (ovf !== '0)     begin errors++; $display("FAIL reset_ovf: got %h expected 0", ovf); end
  endtask

  task automatic test_elementwise();
    mat_t m, bb;
    run_op(OP_ADD, 3, fill(100), fill(50), 1, "add_sat", -1);
    run_op(OP_SUB, 2, fill(-128), fill(1), 1, "sub_sat", -1);
    m = rand_mat();
    m = set_el(m, 0, 0, -128);
    m = set_el(m, 0, 1, 5);
    run_op(OP_OPP, 2, m, rand_mat(), 1, "opp", -1);
    m = rand_mat();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m = set_el(m, i, j, i * 4 + j);
    run_op(OP_TRN, 4, m, rand_mat(), 1, "transpose", -1);
    m  = set_el(rand_mat(), 0, 0, 50);
    bb = set_el(rand_mat(), 0, 0, -3);
    run_op(OP_SCAL, 3, m, bb, 1, "scalar", -1);
    run_op(OP_CLR, 5, rand_mat(), rand_mat(), 1, "clear", -1);
  endtask

  task automatic test_random();
    logic [2:0] rops [6];
    rops = '{OP_ADD, OP_SUB, OP_SCAL, OP_TRN, OP_OPP, OP_ADD};
    for (int i = 0; i < 6; i++)
      run_op(rops[i], int'($urandom_range(2, N)), rand_mat(), rand_mat(), 1, "random_ew", -1);
  endtask

  task automatic test_matmul();
    mat_t ma, mb;
    ma = '0; mb = '0;
    ma = set_el(ma, 0, 0, 1); ma = set_el(ma, 0, 1, 2);
    ma = set_el(ma, 1, 0, 3); ma = set_el(ma, 1, 1, 4);
    mb = set_el(mb, 0, 0, 5); mb = set_el(mb, 0, 1, 6);
    mb = set_el(mb, 1, 0, 7); mb = set_el(mb, 1, 1, 8);
    run_op(OP_MUL, 2, ma, mb, 8, "mul2x2", -1);
    run_op(OP_MUL, 5, fill(10), fill(10), 125, "mul5x5_sat", -1);
    run_op(OP_MUL, 3, rand_mat(), rand_mat(), 27, "mul3x3_rand", -1);
  endtask

  task automatic test_errors();
    run_op(OP_RSVD, 3, rand_mat(), rand_mat(), 1, "err_rsvd", -1);
    run_op(OP_ADD, 1, rand_mat(), rand_mat(), 1, "err_size1", -1);
    run_op(OP_MUL, 6, rand_mat(), rand_mat(), 1, "err_size6", -1);
  endtask

  task automatic test_start_ignored();
    run_op(OP_MUL, 3, rand_mat(), rand_mat(), 27, "mul_start_ignored", 10);
  endtask

  task automatic test_async_reset();
    mat_t ma, mb;
    @(negedge clk);
    op = OP_MUL; size = 3'd5; a = fill(10); b = fill(10); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || result === '0) begin
      errors++;
      $display("FAIL mid_mac_state: busy=%b result=%h expected busy 1 and partial result", busy, result);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL arst_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL arst_err: got %b expected 0", err); end
    checks++; if (result !== '0)   begin errors++; $display("FAIL arst_result: got %h expected 0", result); end
    checks++; if (ovf !== '0)      begin errors++; $display("FAIL arst_ovf: got %h expected 0", ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    model_res = '0;
    model_ovf = '0;
    ma = '0; mb = '0;
    ma = set_el(ma, 0, 0, 1); ma = set_el(ma, 0, 1, 2);
    ma = set_el(ma, 1, 0, 3); ma = set_el(ma, 1, 1, 4);
    mb = set_el(mb, 0, 0, 5); mb = set_el(mb, 0, 1, 6);
    mb = set_el(mb, 1, 0, 7); mb = set_el(mb, 1, 1, 8);
    run_op(OP_MUL, 2, ma, mb, 8, "mul2x2_after_reset", -1);
  endtask

  initial begin
    test_reset();
    test_elementwise();
    test_matmul();
    test_errors();
    test_start_ignored();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
